// File: rtl/pipe_stage_ctrl.sv
// Stage-control unit for the 5-stage pipeline: per-stage rst/en generation for bubbles,
// branch flushes and single-step debug, plus cycle/stall/flush counters.
module pipe_stage_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic              reg_stall,
  input  logic              branch_taken,
  output logic              if_rst,
  output logic              if_en,
  output logic              id_rst,
  output logic              id_en,
  output logic              exe_rst,
  output logic              exe_en,
  output logic              mem_rst,
  output logic              mem_en,
  output logic              wb_rst,
  output logic              wb_en,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT, S_STEP} state_t;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       step_q;
  logic       step_edge;
  logic       advance;

  assign step_edge = debug_step & ~step_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      hold_cnt  <= '0;
      step_q    <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      step_q   <= debug_step;
      if (advance) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        // A flush swallows any simultaneous stall, so only one of the two counts.
        if (branch_taken) begin
          if (flush_cnt != '1) flush_cnt <= flush_cnt + STAT_W'(1);
        end else if (reg_stall) begin
          if (stall_cnt != '1) stall_cnt <= stall_cnt + STAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    advance   = 1'b0;
    case (state)
      S_INIT: begin
        if (hold_cnt == 4'(RST_CYCLES - 1)) begin
          hold_nxt  = '0;
          state_nxt = debug_en ? S_HALT : S_RUN;
        end else begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      S_RUN: begin
        advance = 1'b1;
        if (debug_en) state_nxt = S_HALT;
      end
      S_HALT: begin
        // Leaving step mode wins over a step request arriving in the same cycle.
        if (!debug_en)     state_nxt = S_RUN;
        else if (step_edge) state_nxt = S_STEP;
      end
      S_STEP: begin
        advance   = 1'b1;
        state_nxt = debug_en ? S_HALT : S_RUN;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Stage controls; a stage held in reset always has its enable driven low.
  always_comb begin
    if_rst  = 1'b0; if_en  = 1'b0;
    id_rst  = 1'b0; id_en  = 1'b0;
    exe_rst = 1'b0; exe_en = 1'b0;
    mem_rst = 1'b0; mem_en = 1'b0;
    wb_rst  = 1'b0; wb_en  = 1'b0;
    running = 1'b0;
    if (rst || state == S_INIT) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (advance) begin
      running = 1'b1;
      if (branch_taken) begin
        if_en   = 1'b1;
        id_rst  = 1'b1;
        exe_rst = 1'b1;
        mem_rst = 1'b1;
        wb_en   = 1'b1;
      end else if (reg_stall) begin
        exe_rst = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
      end else begin
        if_en  = 1'b1;
        id_en  = 1'b1;
        exe_en = 1'b1;
        mem_en = 1'b1;
        wb_en  = 1'b1;
      end
    end
  end

endmodule
